mlp_infer_engine: RTL and testbench

- Parametrised two-layer fixed-point MLP inference engine (dense, ReLU, dense, argmax). It is the next generation of the NN top.
- Uses one time-multiplexed MAC instead of per-node matmul instances.
- Has a start/done handshake, a streamed input, and one external weight-memory read port.
- Argmax is computed synchronously; there is no edge-triggered logic on data signals.

---
 rtl/mlp_pkg.sv | 34 +++
 rtl/mlp_infer_engine_if.sv | 28 ++
 rtl/mlp_mac.sv | 31 +++
 rtl/mlp_infer_engine.sv | 159 +++++++++++++++
 tb/tb_mlp_infer_engine.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_pkg.sv
// Shared state encoding and arithmetic helpers for the MLP inference engine.
package mlp_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, L1_MAC, L1_WB, L2_MAC, L2_WB, DONE} state_t;

  localparam int WIDE_W = 128;
  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic int maxOf(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Wide enough that IN_DIM or HID_DIM full-scale products can never overflow.
  function automatic int accWidth(int dataW, int inDim, int hidDim);
    return 2 * dataW + $clog2(maxOf(inDim, hidDim));
  endfunction

  function automatic int l2Base(int inDim, int hidDim);
    return inDim * hidDim;
  endfunction

  function automatic wide_t shiftSat(wide_t acc, int fracW, int dataW);
    wide_t sh;
    wide_t hi;
    wide_t lo;
    sh = acc >>> fracW;
    hi = (wide_t'(1) <<< (dataW - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (dataW - 1));
    if (sh > hi) return hi;
    if (sh < lo) return lo;
    return sh;
  endfunction

endpackage

// File: rtl/mlp_infer_engine_if.sv
// Start/done handshake, streamed input and weight-read port of the MLP engine.
interface mlp_infer_engine_if #(
  parameter int DATA_W   = 32,
  parameter int W_ADDR_W = 17,
  parameter int CLS_W    = 4
);
  logic                start;
  logic                busy;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [W_ADDR_W-1:0] w_addr;
  logic                w_rd_en;
  logic [DATA_W-1:0]   w_data;
  logic                done;
  logic [CLS_W-1:0]    digit_out;
  logic [DATA_W-1:0]   max_logit;

  modport master (
    output start, in_valid, in_data, w_data,
    input  busy, in_ready, w_addr, w_rd_en, done, digit_out, max_logit
  );

  modport slave (
    input  start, in_valid, in_data, w_data,
    output busy, in_ready, w_addr, w_rd_en, done, digit_out, max_logit
  );
endinterface

// File: rtl/mlp_mac.sv
// Signed multiply-accumulate; result is the accumulator rescaled and saturated to DATA_W.
module mlp_mac
  import mlp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 23,
  parameter int ACC_W  = 74
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] result
);
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;

  assign prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr ? ACC_W'(prod) : acc + ACC_W'(prod);
    end
  end

  assign result = DATA_W'(shiftSat(wide_t'(acc), FRAC_W, DATA_W));
endmodule

// File: rtl/mlp_infer_engine.sv
// Two-layer fixed-point MLP (dense, ReLU, dense, argmax) on a single time-multiplexed MAC.
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting IN_DIM input samples
// L1_MAC | issuing layer-1 weight reads for neuron h, then one drain cycle
// L1_WB  | ReLU and store hidden[h]
// L2_MAC | issuing layer-2 weight reads for output o, then one drain cycle
// L2_WB  | running argmax over logits
// DONE   | one-cycle done pulse with result
module mlp_infer_engine
  import mlp_pkg::*;
#(
  parameter int IN_DIM    = 784,
  parameter int HID_DIM   = 110,
  parameter int OUT_DIM   = 10,
  parameter int DATA_W    = 32,
  parameter int FRAC_W    = 23,
  parameter int BIN_INPUT = 1,
  parameter int W_ADDR_W  = 17,
  parameter int CLS_W     = 4
) (
  input logic               clk,
  input logic               reset,
  mlp_infer_engine_if.slave bus
);
  localparam int ACC_W     = accWidth(DATA_W, IN_DIM, HID_DIM);
  localparam int L2_BASE   = l2Base(IN_DIM, HID_DIM);
  localparam int CNT_W     = $clog2(maxOf(maxOf(IN_DIM, HID_DIM), OUT_DIM) + 1);
  localparam int IN_IDX_W  = $clog2(IN_DIM);
  localparam int HID_IDX_W = $clog2(HID_DIM);

  typedef logic signed [DATA_W-1:0] word_t;

  state_t            state;
  logic [CNT_W-1:0]  kCnt;
  logic [CNT_W-1:0]  nCnt;
  logic [CNT_W-1:0]  kLast;
  word_t             inBuf  [IN_DIM];
  word_t             hidBuf [HID_DIM];
  word_t             sample;
  word_t             opQ;
  word_t             macResult;
  word_t             runMax;
  logic [CLS_W-1:0]  runDig;
  logic              macEn;
  logic              macClr;
  logic              takeMax;

  always_comb begin
    kLast = CNT_W'(IN_DIM - 1);
    if (state == L2_MAC) kLast = CNT_W'(HID_DIM - 1);
    sample = bus.in_data;
    if (BIN_INPUT != 0) sample = bus.in_data[0] ? word_t'(1 <<< FRAC_W) : '0;
    takeMax = (nCnt == '0) || (macResult > runMax);
  end

  // Operand is fetched alongside its weight address and lands with w_data a cycle later.
  always_ff @(posedge clk) begin
    if (state == LOAD && bus.in_ready && bus.in_valid) inBuf[kCnt[IN_IDX_W-1:0]] <= sample;
    if (state == L1_WB) hidBuf[nCnt[HID_IDX_W-1:0]] <= macResult[DATA_W-1] ? '0 : macResult;
    if (bus.w_rd_en) begin
      opQ <= (state == L2_MAC) ? hidBuf[kCnt[HID_IDX_W-1:0]] : inBuf[kCnt[IN_IDX_W-1:0]];
    end
  end

  mlp_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rst   (reset),
    .clr   (macClr),
    .en    (macEn),
    .a     (opQ),
    .b     ($signed(bus.w_data)),
    .result(macResult)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      kCnt          <= '0;
      nCnt          <= '0;
      macEn         <= 1'b0;
      macClr        <= 1'b0;
      runMax        <= '0;
      runDig        <= '0;
      bus.busy      <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.w_rd_en   <= 1'b0;
      bus.w_addr    <= '0;
      bus.done      <= 1'b0;
      bus.digit_out <= '0;
      bus.max_logit <= '0;
    end else begin
      bus.done <= 1'b0;
      macEn    <= bus.w_rd_en;
      macClr   <= bus.w_rd_en && (kCnt == '0);
      case (state)
        IDLE: if (bus.start) begin
          state        <= LOAD;
          bus.busy     <= 1'b1;
          bus.in_ready <= 1'b1;
          kCnt         <= '0;
        end
        LOAD: if (bus.in_valid) begin
          if (kCnt == CNT_W'(IN_DIM - 1)) begin
            state        <= L1_MAC;
            bus.in_ready <= 1'b0;
            bus.w_rd_en  <= 1'b1;
            bus.w_addr   <= '0;
            kCnt         <= '0;
            nCnt         <= '0;
          end else begin
            kCnt <= kCnt + CNT_W'(1);
          end
        end
        L1_MAC, L2_MAC: if (bus.w_rd_en) begin
          kCnt       <= kCnt + CNT_W'(1);
          bus.w_addr <= bus.w_addr + W_ADDR_W'(1);
          if (kCnt == kLast) bus.w_rd_en <= 1'b0;
        end else begin
          state <= (state == L1_MAC) ? L1_WB : L2_WB;
        end
        L1_WB: begin
          kCnt        <= '0;
          bus.w_rd_en <= 1'b1;
          if (nCnt == CNT_W'(HID_DIM - 1)) begin
            state      <= L2_MAC;
            nCnt       <= '0;
            bus.w_addr <= W_ADDR_W'(L2_BASE);
          end else begin
            state <= L1_MAC;
            nCnt  <= nCnt + CNT_W'(1);
          end
        end
        L2_WB: begin
          if (takeMax) begin
            runMax <= macResult;
            runDig <= CLS_W'(nCnt);
          end
          if (nCnt == CNT_W'(OUT_DIM - 1)) begin
            state         <= DONE;
            bus.done      <= 1'b1;
            bus.digit_out <= takeMax ? CLS_W'(nCnt) : runDig;
            bus.max_logit <= takeMax ? macResult : runMax;
          end else begin
            state       <= L2_MAC;
            nCnt        <= nCnt + CNT_W'(1);
            kCnt        <= '0;
            bus.w_rd_en <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mlp_infer_engine.sv
// Self-checking bench: directed table, randomized runs against a plain-arithmetic MLP model,
// mid-run reset and start-while-busy sequences.
module tb_mlp_infer_engine;
  localparam int IN_DIM   = 4;
  localparam int HID_DIM  = 3;
  localparam int OUT_DIM  = 3;
  localparam int DATA_W   = 16;
  localparam int FRAC_W   = 8;
  localparam int W_ADDR_W = 5;
  localparam int CLS_W    = 2;
  localparam int L2_BASE  = IN_DIM * HID_DIM;
  localparam int NW       = L2_BASE + HID_DIM * OUT_DIM;
  localparam int EXP_LAT  = HID_DIM * (IN_DIM + 2) + OUT_DIM * (HID_DIM + 2) + 1;
  localparam int TMO      = 300;
  localparam int NVEC     = 6;

  typedef struct {
    logic [DATA_W-1:0]                x;
    logic [DATA_W-1:0]                w1;
    logic [0:OUT_DIM-1][DATA_W-1:0]   w2;
    int                               gap;
    int                               expDig;
    longint                           expMax;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int doneCnt = 0;
  int rdCnt = 0;
  logic [DATA_W-1:0] xin  [IN_DIM];
  logic [DATA_W-1:0] wmem [32];
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  mlp_infer_engine_if #(.DATA_W(DATA_W), .W_ADDR_W(W_ADDR_W), .CLS_W(CLS_W)) bus ();

  mlp_infer_engine #(
    .IN_DIM(IN_DIM), .HID_DIM(HID_DIM), .OUT_DIM(OUT_DIM), .DATA_W(DATA_W),
    .FRAC_W(FRAC_W), .BIN_INPUT(0), .W_ADDR_W(W_ADDR_W), .CLS_W(CLS_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Weight memory with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.w_rd_en) begin
      bus.w_data <= wmem[bus.w_addr];
      rdCnt      <= rdCnt + 1;
    end
  end

  always @(negedge clk) if (bus.done) doneCnt <= doneCnt + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic loadVec(input vec_t v);
    for (int i = 0; i < IN_DIM; i++) xin[i] = v.x;
    for (int j = 0; j < L2_BASE; j++) wmem[j] = v.w1;
    for (int o = 0; o < OUT_DIM; o++)
      for (int h = 0; h < HID_DIM; h++) wmem[L2_BASE + o * HID_DIM + h] = v.w2[o];
  endtask

  task automatic randVec();
    int r;
    for (int i = 0; i < IN_DIM; i++) begin
      r = int'($urandom_range(0, 1023)) - 512;
      xin[i] = DATA_W'(r);
    end
    for (int j = 0; j < NW; j++) begin
      r = int'($urandom_range(0, 1023)) - 512;
      wmem[j] = DATA_W'(r);
    end
  endtask

  function automatic longint sat(input longint v);
    longint hi = (longint'(1) <<< (DATA_W - 1)) - 1;
    longint lo = -(longint'(1) <<< (DATA_W - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference: dense -> ReLU -> dense -> argmax, lowest index on ties.
  task automatic model(output int dig, output longint mx);
    longint hid [HID_DIM];
    longint acc;
    longint lg;
    dig = 0;
    mx = 0;
    for (int h = 0; h < HID_DIM; h++) begin
      acc = 0;
      for (int i = 0; i < IN_DIM; i++)
        acc += longint'($signed(xin[i])) * longint'($signed(wmem[h * IN_DIM + i]));
      hid[h] = sat(acc >>> FRAC_W);
      if (hid[h] < 0) hid[h] = 0;
    end
    for (int o = 0; o < OUT_DIM; o++) begin
      acc = 0;
      for (int h = 0; h < HID_DIM; h++)
        acc += hid[h] * longint'($signed(wmem[L2_BASE + o * HID_DIM + h]));
      lg = sat(acc >>> FRAC_W);
      if (o == 0 || lg > mx) begin
        mx = lg;
        dig = o;
      end
    end
  endtask

  task automatic startAndLoad(input int gap, input string tag);
    int got = 0;
    int cyc = 0;
    bit accept;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (got < IN_DIM && cyc < TMO) begin
      case (gap)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = (cyc % 2 == 1);
        default: bus.in_valid = ($urandom_range(0, 1) == 1);
      endcase
      bus.in_data = xin[got];
      accept = bus.in_valid && bus.in_ready;
      @(posedge clk);
      cyc++;
      if (accept) got++;
      #1;
    end
    bus.in_valid = 1'b0;
    check($sformatf("%s samples accepted", tag), got, IN_DIM);
    check($sformatf("%s in_ready after last accept", tag), bus.in_ready, 0);
  endtask

  task automatic waitDone(input bit noise, output int lat);
    int cyc = 0;
    lat = -1;
    while (cyc < TMO) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done) begin
        lat = cyc + 1;
        break;
      end
      bus.start = noise && (cyc >= 2) && (cyc < 12) && (cyc % 2 == 0);
    end
    bus.start = 1'b0;
  endtask

  task automatic runCase(input int gap, input bit noise, input int expDig, input longint expMax,
                         input string tag);
    int lat;
    int r0;
    r0 = rdCnt;
    startAndLoad(gap, tag);
    waitDone(noise, lat);
    check($sformatf("%s latency", tag), lat, EXP_LAT);
    check($sformatf("%s digit_out", tag), bus.digit_out, expDig);
    check($sformatf("%s max_logit", tag), longint'($signed(bus.max_logit)), expMax);
    @(posedge clk);
    #1;
    check($sformatf("%s done width", tag), bus.done, 0);
    check($sformatf("%s busy after done", tag), bus.busy, 0);
    check($sformatf("%s weight reads", tag), rdCnt - r0, NW);
    check($sformatf("%s max_logit held", tag), longint'($signed(bus.max_logit)), expMax);
  endtask

  initial begin
    int d0;
    int cyc;
    int dig;
    longint mx;

    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    vecs[0] = '{x: 16'h0100, w1: 16'h0080, w2: {16'h0000, 16'h0000, 16'h0100},
                gap: 0, expDig: 2, expMax: 1536};
    vecs[1] = '{x: 16'h0100, w1: 16'hFF00, w2: {16'h0100, 16'h0100, 16'h0100},
                gap: 0, expDig: 0, expMax: 0};
    vecs[2] = '{x: 16'h7FFF, w1: 16'h7FFF, w2: {16'h0000, 16'h0100, 16'hFF00},
                gap: 0, expDig: 1, expMax: 32767};
    vecs[3] = '{x: 16'h0100, w1: 16'h0080, w2: {16'h0000, 16'h0000, 16'h0100},
                gap: 1, expDig: 2, expMax: 1536};
    vecs[4] = '{x: 16'h0100, w1: 16'h0080, w2: {16'h0100, 16'h0100, 16'h0080},
                gap: 2, expDig: 0, expMax: 1536};
    vecs[5] = '{x: 16'h0100, w1: 16'h0080, w2: {16'hFF00, 16'h0040, 16'hFF80},
                gap: 0, expDig: 1, expMax: 384};

    repeat (2) @(negedge clk);
    check("reset busy", bus.busy, 0);
    check("reset in_ready", bus.in_ready, 0);
    check("reset w_rd_en", bus.w_rd_en, 0);
    check("reset done", bus.done, 0);
    check("reset w_addr", bus.w_addr, 0);
    check("reset digit_out", bus.digit_out, 0);
    check("reset max_logit", bus.max_logit, 0);
    reset = 1'b0;

    for (int v = 0; v < NVEC; v++) begin
      loadVec(vecs[v]);
      runCase(vecs[v].gap, 1'b0, vecs[v].expDig, vecs[v].expMax, $sformatf("vec%0d", v));
    end

    for (int r = 0; r < 10; r++) begin
      randVec();
      model(dig, mx);
      runCase(2, 1'b0, dig, mx, $sformatf("rand%0d", r));
    end

    // Reset in the middle of layer-1 accumulation.
    loadVec(vecs[5]);
    d0 = doneCnt;
    startAndLoad(0, "rst");
    cyc = 0;
    while (!bus.w_rd_en && cyc < TMO) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("rst reached L1_MAC", bus.w_rd_en, 1);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst busy drops", bus.busy, 0);
    check("rst w_rd_en drops", bus.w_rd_en, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("rst no done", doneCnt - d0, 0);
    runCase(0, 1'b0, vecs[5].expDig, vecs[5].expMax, "after_rst");
    check("after_rst one done", doneCnt - d0, 1);

    // Start pulses while busy must not spawn extra runs.
    loadVec(vecs[0]);
    d0 = doneCnt;
    runCase(0, 1'b1, vecs[0].expDig, vecs[0].expMax, "noise");
    repeat (60) @(negedge clk);
    check("noise one done", doneCnt - d0, 1);
    check("noise idle busy", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
